// File: rtl/secuenciador_mux_ent.sv
// secuenciador_mux_ent: sequencer for the entry multiplexer that feeds the RTC
// write bus. On start it walks the enabled channels in ascending order. For each
// channel it selects the mux, latches the byte, and offers it on a req/ack bus.
// A per-transfer timeout aborts the sweep and sets a sticky error flag.
module secuenciador_mux_ent #(
    parameter int N_CH   = 14,
    parameter int DW     = 8,
    parameter int TO_CYC = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N_CH-1:0] mask,
    input  logic [DW-1:0]   dato_in,
    input  logic            wr_ack,
    output logic [3:0]      sel,
    output logic            r_s,
    output logic [3:0]      dir,
    output logic [DW-1:0]   dato_out,
    output logic            wr_req,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_LATCH,
        S_REQ,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      dir_q, dir_d;
    logic [DW-1:0]   dato_q, dato_d;
    logic            err_q, err_d;
    logic            wr_req_q, busy_q, done_q;
    logic [N_CH-1:0] rem;

    // Index of the lowest set bit; only meaningful when m is non-zero.
    function automatic logic [3:0] lowest(input logic [N_CH-1:0] m);
        logic       found;
        logic [3:0] r;
        found = 1'b0;
        r     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (m[i] && !found) begin
                r     = 4'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Next-state and datapath updates for the sweep.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        dato_d  = dato_q;
        err_d   = err_q;
        rem     = mask_q & ~(N_CH'(1) << idx_q);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (|mask) begin
                        mask_d  = mask;
                        idx_d   = lowest(mask);
                        state_d = S_SEL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEL: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                dato_d  = dato_in;
                dir_d   = idx_q;
                cnt_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (wr_ack) begin
                    mask_d = rem;
                    if (|rem) begin
                        idx_d   = lowest(rem);
                        state_d = S_SEL;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (cnt_q == CW'(TO_CYC - 1)) begin
                    // cnt_q counts REQ cycles already spent, so this is the
                    // TO_CYC-th cycle without an ack.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake/status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= '0;
            dato_q   <= '0;
            err_q    <= 1'b0;
            wr_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            dato_q   <= dato_d;
            err_q    <= err_d;
            wr_req_q <= (state_d == S_REQ);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    // Mux select/enable held through SEL, LATCH and REQ.
    always_comb begin
        sel = '0;
        r_s = 1'b0;
        if (state_q == S_SEL || state_q == S_LATCH || state_q == S_REQ) begin
            sel = idx_q;
            r_s = 1'b1;
        end
    end

    assign dir      = dir_q;
    assign dato_out = dato_q;
    assign wr_req   = wr_req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_secuenciador_mux_ent.sv
// Scoreboard bench for secuenciador_mux_ent: expected transfers and done
// pulses are queued by the stimulus; a monitor checks them as they occur.
module tb_secuenciador_mux_ent;

    localparam int N_CH = 14;
    localparam int DW   = 8;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [N_CH-1:0] mask = '0;
    logic [DW-1:0]   dato_in;
    logic            wr_ack = 1'b0;
    logic [3:0]      sel;
    logic            r_s;
    logic [3:0]      dir;
    logic [DW-1:0]   dato_out;
    logic            wr_req;
    logic            busy;
    logic            done;
    logic            err;

    secuenciador_mux_ent #(
        .N_CH   (N_CH),
        .DW     (DW),
        .TO_CYC (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mask     (mask),
        .dato_in  (dato_in),
        .wr_ack   (wr_ack),
        .sel      (sel),
        .r_s      (r_s),
        .dir      (dir),
        .dato_out (dato_out),
        .wr_req   (wr_req),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: each channel presents base + channel index when enabled.
    logic [7:0] base = 8'hA0;
    assign dato_in = r_s ? (base + {4'h0, sel}) : 8'h00;

    // Bus model: constant ack level, or ack on the ack_at-th cycle of wr_req.
    int   ack_mode  = 0;
    logic ack_level = 1'b0;
    int   ack_at    = 1;
    int   hi_cnt    = 0;
    always @(posedge clk) begin
        #1;
        if (wr_req) hi_cnt = hi_cnt + 1;
        else        hi_cnt = 0;
        if (ack_mode == 0) wr_ack = ack_level;
        else               wr_ack = wr_req && (hi_cnt >= ack_at);
    end

    typedef struct {
        logic [3:0] dir;
        logic [7:0] dato;
        int         len;
        int         acked;
    } xfer_t;

    typedef struct {
        int err;
        int lat;
    } done_t;

    xfer_t xq[$];
    done_t dq[$];

    int errors = 0;
    int checks = 0;
    int start_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks each wr_req window and each done pulse.
    logic       in_req = 1'b0;
    int         run_len = 0;
    logic [3:0] first_dir;
    logic [7:0] first_dato;
    int         stable = 1;
    int         last_ack = 0;
    int         busy_run = 0;
    always @(negedge clk) begin
        xfer_t e;
        done_t d;
        if (busy) busy_run = busy_run + 1;
        else      busy_run = 0;
        if (wr_req) begin
            if (!in_req) begin
                in_req     = 1'b1;
                run_len    = 0;
                first_dir  = dir;
                first_dato = dato_out;
                stable     = 1;
            end else if (dir != first_dir || dato_out != first_dato) begin
                stable = 0;
            end
            run_len  = run_len + 1;
            last_ack = int'(wr_ack);
        end else if (in_req) begin
            in_req = 1'b0;
            if (xq.size() == 0) begin
                chk("unexpected_xfer_dir", int'(first_dir), -1);
            end else begin
                e = xq.pop_front();
                chk("xfer_dir", int'(first_dir), int'(e.dir));
                chk("xfer_dato", int'(first_dato), int'(e.dato));
                chk("xfer_len", run_len, e.len);
                chk("xfer_acked", last_ack, e.acked);
                chk("xfer_stable", stable, 1);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                d = dq.pop_front();
                chk("done_err", int'(err), d.err);
                chk("done_lat", cyc - start_cyc + 1, d.lat);
                chk("busy_run", busy_run, d.lat);
            end
        end
    end

    task automatic do_start(input logic [N_CH-1:0] m);
        @(posedge clk);
        #1;
        start = 1'b1;
        mask  = m;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL wait_idle: busy still high after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a start held during reset.
        reset = 1'b0;
        start = 1'b1;
        mask  = 14'h3FFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", int'(sel), 0);
        chk("rst_r_s", int'(r_s), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_dato", int'(dato_out), 0);
        chk("rst_wr_req", int'(wr_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b1;
        start = 1'b0;
        mask  = '0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", int'(busy), 0);

        // Full sweep, immediate ack.
        base      = 8'hA0;
        ack_mode  = 0;
        ack_level = 1'b1;
        for (int i = 0; i < N_CH; i++) xq.push_back('{4'(i), 8'(8'hA0 + i), 1, 1});
        dq.push_back('{0, 43});
        do_start(14'h3FFF);
        wait_idle();

        // Empty mask: straight to done, no bus request.
        dq.push_back('{0, 1});
        do_start(14'h0000);
        wait_idle();

        // Sparse mask, ack on the 5th request cycle, start pulsed while busy.
        base     = 8'h50;
        ack_mode = 1;
        ack_at   = 5;
        xq.push_back('{4'd0, 8'h50, 5, 1});
        xq.push_back('{4'd2, 8'h52, 5, 1});
        xq.push_back('{4'd13, 8'h5D, 5, 1});
        dq.push_back('{0, 22});
        do_start(14'h2005);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        mask  = 14'h3FFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Timeout: no ack at all.
        base      = 8'h30;
        ack_mode  = 0;
        ack_level = 1'b0;
        xq.push_back('{4'd0, 8'h30, TO, 0});
        dq.push_back('{1, 2 + TO + 1});
        do_start(14'h0001);
        wait_idle();
        chk("err_sticky", int'(err), 1);

        // Next accepted start clears err.
        ack_level = 1'b1;
        xq.push_back('{4'd0, 8'h30, 1, 1});
        dq.push_back('{0, 4});
        do_start(14'h0001);
        wait_idle();
        chk("err_cleared", int'(err), 0);

        // Ack on exactly the TO-th request cycle is accepted.
        ack_mode = 1;
        ack_at   = TO;
        xq.push_back('{4'd4, 8'h34, TO, 1});
        dq.push_back('{0, 2 + TO + 1});
        do_start(14'h0010);
        wait_idle();
        chk("err_last_cycle_ack", int'(err), 0);

        // Reset while in REQ for channel 5.
        base     = 8'h70;
        ack_mode = 1;
        ack_at   = 2;
        xq.push_back('{4'd0, 8'h70, 2, 1});
        xq.push_back('{4'd5, 8'h75, 1, 0});
        do_start(14'h0021);
        begin
            int n;
            for (n = 0; n < 200; n++) begin
                @(negedge clk);
                if (wr_req && dir == 4'd5) break;
            end
            checks++;
            if (n >= 200) begin
                errors++;
                $display("FAIL wait_ch5: no request for channel 5 within %0d cycles", n);
            end
        end
        ack_mode  = 0;
        ack_level = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_wr_req", int'(wr_req), 0);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Fresh start after the aborted sweep begins at the lowest set bit.
        ack_level = 1'b1;
        xq.push_back('{4'd0, 8'h70, 1, 1});
        xq.push_back('{4'd5, 8'h75, 1, 1});
        dq.push_back('{0, 7});
        do_start(14'h0021);
        wait_idle();

        chk("xq_empty", xq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
